// File: rtl/riscv_pkg.sv
// Shared types for the load/store unit: access sizes, FSM states and a
// misalignment helper used when LSU_MISALIGN_TRAP_EN is defined.
package riscv_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    // True when the access does not sit on its natural boundary.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        return ((size == HALF) && addr_lo[0]) || ((size == WORD) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: byte enables and store-data replication for
// the outgoing request, and shift/mask/extend for the returning load data.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_raw,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [31:0] shifted;

    // Select lanes by size; misaligned HALF/WORD fall back to the aligned lanes.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        be        = 4'b0000;
        wdata_rep = 32'h0;
        shifted   = rdata_raw;
        rdata_ext = 32'h0;
        case (size)
            BYTE: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                shifted   = rdata_raw >> {addr_lo, 3'b000};
                rdata_ext = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
            end
            HALF: begin
                be        = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
                shifted   = rdata_raw >> {addr_lo[1], 4'b0000};
                rdata_ext = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
            end
            WORD: begin
                be        = 4'b1111;
                wdata_rep = wdata;
                rdata_ext = shifted;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one operation at a time from execute, issues a
// single data-memory request, waits (bounded by RESP_TIMEOUT) for load data
// and pulses done_o. Optional macro LSU_MISALIGN_TRAP_EN turns misaligned
// HALF/WORD accesses into an immediate error completion.
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int RESP_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        lsu_valid_i,
    output logic        lsu_ready_o,
    input  logic        lsu_store_i,
    input  logic [1:0]  lsu_size_i,
    input  logic        lsu_unsigned_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        dmem_req_o,
    input  logic        dmem_gnt_i,
    output logic        dmem_we_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic [31:0] rdata_o,
    output logic        done_o,
    output logic        err_o
);

    lsu_state_t  state, next_state;
    logic        op_store, op_unsigned, err_q;
    logic [1:0]  op_size;
    logic [31:0] op_addr, op_wdata, rdata_q;
    logic [15:0] cnt;
    logic        accept, bad_op, trap, timeout;
    logic [3:0]  be;
    logic [31:0] wdata_rep, rdata_ext;

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = is_misaligned(lsu_size_i, addr_i[1:0]);
`else
    assign trap = 1'b0;
`endif

    assign bad_op  = (lsu_size_i == 2'd3) || trap;
    assign timeout = (state == WAIT) && (cnt == 16'(RESP_TIMEOUT - 1));

    lsu_align u_align (
        .size        (op_size),
        .addr_lo     (op_addr[1:0]),
        .is_unsigned (op_unsigned),
        .wdata       (op_wdata),
        .rdata_raw   (dmem_rdata_i),
        .be          (be),
        .wdata_rep   (wdata_rep),
        .rdata_ext   (rdata_ext)
    );

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state and FSM-derived handshake outputs.
    always_comb begin
        next_state  = state;
        accept      = 1'b0;
        lsu_ready_o = 1'b0;
        dmem_req_o  = 1'b0;
        done_o      = 1'b0;
        case (state)
            IDLE: begin
                lsu_ready_o = 1'b1;
                if (lsu_valid_i) begin
                    accept     = 1'b1;
                    next_state = bad_op ? DONE : REQ;
                end
            end
            REQ: begin
                dmem_req_o = 1'b1;
                if (dmem_gnt_i) next_state = op_store ? DONE : WAIT;
            end
            WAIT: if (dmem_rvalid_i || timeout) next_state = DONE;
            DONE: begin
                done_o     = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Operation capture, response counter and load result.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_store    <= 1'b0;
            op_unsigned <= 1'b0;
            op_size     <= 2'd0;
            op_addr     <= 32'h0;
            op_wdata    <= 32'h0;
            cnt         <= 16'h0;
            rdata_q     <= 32'h0;
            err_q       <= 1'b0;
        end else begin
            if (accept) begin
                op_store    <= lsu_store_i;
                op_unsigned <= lsu_unsigned_i;
                op_size     <= lsu_size_i;
                op_addr     <= addr_i;
                op_wdata    <= wdata_i;
                err_q       <= bad_op;
            end
            if (state == REQ && dmem_gnt_i) cnt <= 16'h0;
            if (state == WAIT) begin
                if (dmem_rvalid_i) begin
                    rdata_q <= rdata_ext;
                    err_q   <= 1'b0;
                end else if (timeout) begin
                    rdata_q <= 32'h0;
                    err_q   <= 1'b1;
                end else begin
                    cnt <= cnt + 16'h1;
                end
            end
        end
    end

    assign dmem_we_o    = dmem_req_o & op_store;
    assign dmem_be_o    = dmem_req_o ? be : 4'b0000;
    assign dmem_addr_o  = {op_addr[31:2], 2'b00};
    assign dmem_wdata_o = wdata_rep;
    assign rdata_o      = rdata_q;
    assign err_o        = done_o & err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random
// operations checked against a lane/byte-level reference model.
module tb_load_store_unit;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        lsu_valid_i = 1'b0, lsu_store_i = 1'b0, lsu_unsigned_i = 1'b0;
    logic [1:0]  lsu_size_i = 2'd0;
    logic [31:0] addr_i = 32'h0, wdata_i = 32'h0;
    logic        dmem_gnt_i = 1'b0, dmem_rvalid_i = 1'b0;
    logic [31:0] dmem_rdata_i = 32'h0;
    logic        lsu_ready_o, dmem_req_o, dmem_we_o, done_o, err_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o, rdata_o;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [31:0] model_rdata = 32'h0;

    load_store_unit #(.RESP_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o),
        .lsu_store_i(lsu_store_i), .lsu_size_i(lsu_size_i),
        .lsu_unsigned_i(lsu_unsigned_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .dmem_req_o(dmem_req_o), .dmem_gnt_i(dmem_gnt_i), .dmem_we_o(dmem_we_o),
        .dmem_be_o(dmem_be_o), .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
        .rdata_o(rdata_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit model_trap(input logic [1:0] sz, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
        if (sz == 2'd1) return a[0];
        if (sz == 2'd2) return (a % 4) != 0;
`endif
        return 1'b0;
    endfunction

    function automatic int nbytes(input logic [1:0] sz);
        return 1 << sz;
    endfunction

    // Lane offset: byte address within the word, rounded down to the access size.
    function automatic int lane_off(input logic [1:0] sz, input logic [31:0] a);
        return ((a % 4) / nbytes(sz)) * nbytes(sz);
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] a);
        return 4'(((1 << nbytes(sz)) - 1) << lane_off(sz, a));
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] r = 32'h0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nbytes(sz)) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input bit uns,
                                               input logic [31:0] a, input logic [31:0] rsp);
        longint unsigned mask = (64'd1 << (8 * nbytes(sz))) - 1;
        longint unsigned v = (64'(rsp) >> (8 * lane_off(sz, a))) & mask;
        if (!uns && v[8*nbytes(sz)-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    // One complete operation; gd = grant withheld cycles, rd = WAIT cycles before rvalid.
    task automatic run_op(input string name, input bit st, input logic [1:0] sz, input bit uns,
                          input logic [31:0] a, input logic [31:0] wd, input int gd,
                          input int rd, input bit no_rsp, input logic [31:0] rsp);
        bit bad = (sz == 2'd3) || model_trap(sz, a);
        int cyc = 0, reqs = 0, exp_done;
        int waits = 0;
        bit fin = 1'b0;
        bit exp_err = bad || (!st && no_rsp);
        if (bad) exp_done = 1;
        else if (st) exp_done = gd + 2;
        else if (no_rsp) exp_done = gd + TMO + 2;
        else exp_done = gd + rd + 3;
        if (!bad && !st) model_rdata = no_rsp ? 32'h0 : model_load(sz, uns, a, rsp);

        total_cnt++;
        if (lsu_ready_o !== 1'b1) $display("FAIL %s ready_idle: got %b want 1", name, lsu_ready_o);
        else pass_cnt++;
        lsu_valid_i = 1'b1; lsu_store_i = st; lsu_size_i = sz;
        lsu_unsigned_i = uns; addr_i = a; wdata_i = wd;

        while (!fin && cyc < 200) begin
            tick();
            cyc++;
            lsu_valid_i = 1'b0; lsu_store_i = 1'($urandom); lsu_size_i = 2'($urandom);
            addr_i = $urandom; wdata_i = $urandom;
            dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = $urandom;
            if (done_o === 1'b1) begin
                fin = 1'b1;
                dmem_rvalid_i = 1'($urandom);
                total_cnt++;
                if (cyc != exp_done) $display("FAIL %s latency: got %0d want %0d", name, cyc, exp_done);
                else pass_cnt++;
                total_cnt++;
                if (err_o !== exp_err) $display("FAIL %s err: got %b want %b", name, err_o, exp_err);
                else pass_cnt++;
                total_cnt++;
                if (rdata_o !== model_rdata) $display("FAIL %s rdata: got %h want %h", name, rdata_o, model_rdata);
                else pass_cnt++;
            end else if (dmem_req_o === 1'b1) begin
                reqs++;
                total_cnt++;
                if (dmem_addr_o !== {a[31:2], 2'b00} || dmem_be_o !== model_be(sz, a) ||
                    dmem_we_o !== st || lsu_ready_o !== 1'b0)
                    $display("FAIL %s req_fields: got addr=%h be=%b we=%b rdy=%b want addr=%h be=%b we=%b rdy=0",
                             name, dmem_addr_o, dmem_be_o, dmem_we_o, lsu_ready_o,
                             {a[31:2], 2'b00}, model_be(sz, a), st);
                else pass_cnt++;
                if (st) begin
                    total_cnt++;
                    if (dmem_wdata_o !== model_wdata(sz, wd))
                        $display("FAIL %s wdata: got %h want %h", name, dmem_wdata_o, model_wdata(sz, wd));
                    else pass_cnt++;
                end
                dmem_rvalid_i = 1'($urandom);
                if (reqs > gd) dmem_gnt_i = 1'b1;
            end else begin
                waits++;
                total_cnt++;
                if (lsu_ready_o !== 1'b0 || dmem_be_o !== 4'b0000)
                    $display("FAIL %s wait_outputs: got rdy=%b be=%b want rdy=0 be=0000", name, lsu_ready_o, dmem_be_o);
                else pass_cnt++;
                if (!no_rsp && waits > rd) begin
                    dmem_rvalid_i = 1'b1;
                    dmem_rdata_i = rsp;
                end
            end
        end
        if (!fin) begin
            total_cnt++;
            $display("FAIL %s done_timeout: got no done_o in %0d cycles want done", name, cyc);
        end
        if (bad) begin
            total_cnt++;
            if (reqs != 0) $display("FAIL %s no_request: got %0d req cycles want 0", name, reqs);
            else pass_cnt++;
        end
        tick();
        dmem_rvalid_i = 1'b0; dmem_gnt_i = 1'b0;
        total_cnt++;
        if (done_o !== 1'b0 || lsu_ready_o !== 1'b1 || rdata_o !== model_rdata)
            $display("FAIL %s after_done: got done=%b rdy=%b rdata=%h want done=0 rdy=1 rdata=%h",
                     name, done_o, lsu_ready_o, rdata_o, model_rdata);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        total_cnt++;
        if (dmem_req_o !== 1'b0 || done_o !== 1'b0 || err_o !== 1'b0 || rdata_o !== 32'h0 ||
            dmem_be_o !== 4'b0000 || dmem_we_o !== 1'b0)
            $display("FAIL reset_outputs: got req=%b done=%b err=%b rdata=%h be=%b we=%b want all 0",
                     dmem_req_o, done_o, err_o, rdata_o, dmem_be_o, dmem_we_o);
        else pass_cnt++;
        reset = 1'b0;
        model_rdata = 32'h0;
        total_cnt++;
        if (lsu_ready_o !== 1'b1) $display("FAIL reset_ready: got %b want 1", lsu_ready_o);
        else pass_cnt++;
    endtask

    task automatic test_directed();
        run_op("store_byte_1003", 1'b1, 2'd0, 1'b0, 32'h1003, 32'h0000_00A5, 0, 0, 1'b0, 32'h0);
        run_op("load_half_signed", 1'b0, 2'd1, 1'b0, 32'h2002, 32'h0, 0, 0, 1'b0, 32'h8001_1234);
        run_op("load_byte_gnt_wait", 1'b0, 2'd0, 1'b1, 32'h0000_4001, 32'h0, 5, 0, 1'b0, 32'h1234_F0AB);
        run_op("load_timeout", 1'b0, 2'd2, 1'b0, 32'h5000, 32'h0, 0, 0, 1'b1, 32'h0);
        run_op("load_rvalid_at_timeout", 1'b0, 2'd2, 1'b0, 32'h5004, 32'h0, 1, TMO - 1, 1'b0, 32'hCAFE_BABE);
        run_op("load_word_3001", 1'b0, 2'd2, 1'b0, 32'h3001, 32'h0, 0, 0, 1'b0, 32'h1122_3344);
        run_op("store_half_misalign", 1'b1, 2'd1, 1'b0, 32'h6003, 32'h0000_BEEF, 2, 0, 1'b0, 32'h0);
        run_op("reserved_size", 1'b0, 2'd3, 1'b0, 32'h7000, 32'h0, 0, 0, 1'b0, 32'h0);
    endtask

    task automatic test_reset_mid_wait();
        lsu_valid_i = 1'b1; lsu_store_i = 1'b0; lsu_size_i = 2'd2; addr_i = 32'h8000;
        tick();
        lsu_valid_i = 1'b0;
        dmem_gnt_i = 1'b1;
        tick();
        dmem_gnt_i = 1'b0;
        total_cnt++;
        if (dmem_req_o !== 1'b0 || done_o !== 1'b0 || lsu_ready_o !== 1'b0)
            $display("FAIL mid_wait_state: got req=%b done=%b rdy=%b want 0 0 0", dmem_req_o, done_o, lsu_ready_o);
        else pass_cnt++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_rdata = 32'h0;
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hDEAD_BEEF;
        total_cnt++;
        if (lsu_ready_o !== 1'b1 || done_o !== 1'b0 || rdata_o !== 32'h0)
            $display("FAIL mid_wait_reset: got rdy=%b done=%b rdata=%h want 1 0 0", lsu_ready_o, done_o, rdata_o);
        else pass_cnt++;
        tick();
        dmem_rvalid_i = 1'b0;
        total_cnt++;
        if (done_o !== 1'b0 || lsu_ready_o !== 1'b1 || rdata_o !== 32'h0)
            $display("FAIL stray_rvalid: got done=%b rdy=%b rdata=%h want 0 1 0", done_o, lsu_ready_o, rdata_o);
        else pass_cnt++;
        run_op("after_reset_load", 1'b0, 2'd0, 1'b0, 32'h8003, 32'h0, 0, 0, 1'b0, 32'h80FF_FFFF);
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            logic [1:0] sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            bit st = 1'($urandom);
            bit nr = ($urandom_range(0, 7) == 0);
            run_op("random", st, sz, 1'($urandom), $urandom, $urandom, $urandom_range(0, 3),
                   $urandom_range(0, TMO - 1), nr, $urandom);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_mid_wait();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter RESP_TIMEOUT, default 255: maximum WAIT cycles allowed for a load response before an error is flagged; legal range 1..65535.
REQ-002 clk  input  1  core clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 lsu_valid_i  input  1  memory operation offered by the execute stage.
REQ-005 lsu_ready_o  output  1  unit can accept an operation this cycle.
REQ-006 lsu_store_i  input  1  1 = store, 0 = load.
REQ-007 lsu_size_i  input  2  access size from riscv_pkg: BYTE=0, HALF=1, WORD=2; value 3 is reserved.
REQ-008 lsu_unsigned_i  input  1  load result is zero-extended when 1 and sign-extended when 0.
REQ-009 addr_i  input  32  byte address, taken from the ALU result.
REQ-010 wdata_i  input  32  store data (rs2).
REQ-011 dmem_req_o  output  1  data memory request.
REQ-012 dmem_gnt_i  input  1  data memory accepts the request.
REQ-013 dmem_we_o  output  1  write enable.
REQ-014 dmem_be_o  output  4  byte-lane enables.
REQ-015 dmem_addr_o  output  32  word address {addr[31:2], 2'b00}.
REQ-016 dmem_wdata_o  output  32  lane-replicated store data.
REQ-017 dmem_rvalid_i  input  1  load response valid.
REQ-018 dmem_rdata_i  input  32  load response data.
REQ-019 rdata_o  output  32  extended load result; held stable until the next operation is accepted.
REQ-020 done_o  output  1  single-cycle completion pulse.
REQ-021 err_o  output  1  error flag; meaningful only while done_o is 1.

Function
REQ-022 FSM states SHALL be IDLE, REQ, WAIT and DONE.
REQ-023 lsu_ready_o SHALL be 1 only in IDLE, and an operation SHALL be accepted, with all inputs registered, when lsu_valid_i && lsu_ready_o.
REQ-024 Transitions SHALL be: IDLE->REQ on accept; REQ->WAIT on load grant; REQ->DONE on store grant; WAIT->DONE on rvalid or timeout; DONE->IDLE unconditionally.
REQ-025 dmem_req_o SHALL be 1 only in REQ, and the request and all dmem_* outputs SHALL be held constant until dmem_gnt_i is sampled high, with no request timeout.
REQ-026 dmem_be_o SHALL be: BYTE = 4'b0001 << addr[1:0]; HALF = 4'b0011 << {addr[1],1'b0}; WORD = 4'b1111.
REQ-027 dmem_wdata_o SHALL be: BYTE = {4{wdata[7:0]}}; HALF = {2{wdata[15:0]}}; WORD = wdata.
REQ-028 Load data SHALL be formed as dmem_rdata_i >> (8*addr[1:0]), masked to the access size, then extended per lsu_unsigned_i, and registered into rdata_o on rvalid in WAIT.
REQ-029 done_o SHALL be 1 for exactly one cycle, in DONE; minimum load latency SHALL be 3 cycles (accept to done) and minimum store latency 2 cycles, given zero-wait grant and response.
REQ-030 A 16-bit counter SHALL clear on entry to WAIT and increment each WAIT cycle; reaching RESP_TIMEOUT without rvalid SHALL go to DONE with err_o=1 and rdata_o=0.
REQ-031 rvalid and rvalid coincident with timeout: rvalid SHALL win, err_o=0.
REQ-032 dmem_rvalid_i outside WAIT SHALL be ignored.
REQ-033 lsu_size_i=3 SHALL go IDLE->DONE with err_o=1 and no memory request.

Reset
REQ-034 Reset SHALL take priority over all inputs and, from any state including mid-request, SHALL force IDLE on the next edge with dmem_req_o=0, done_o=0, err_o=0, rdata_o=0, counter=0, dmem_be_o=0, dmem_we_o=0; lsu_ready_o SHALL be 1 from the first cycle after reset deasserts.

Configuration
REQ-035 With LSU_MISALIGN_TRAP_EN defined, HALF with addr[0]=1 or WORD with addr[1:0]!=0 SHALL go IDLE->DONE with err_o=1, no dmem request, and rdata_o unchanged.
REQ-036 Without LSU_MISALIGN_TRAP_EN, misaligned accesses SHALL proceed: HALF ignores addr[0], WORD ignores addr[1:0], and err_o SHALL never be set for misalignment.

Structure
REQ-037 riscv_pkg SHALL hold the mem_size_t enum (BYTE/HALF/WORD) and the lsu_state_t enum (IDLE/REQ/WAIT/DONE).
REQ-038 Lane steering and extension SHALL be a combinational sub-module, lsu_align, instantiated once in load_store_unit.

Verification
REQ-039 Store BYTE, addr=0x1003, wdata=0xA5, grant in the first REQ cycle -> be=1000, wdata=0xA5A5A5A5, dmem_addr=0x1000, done_o at cycle 2, err_o=0.
REQ-040 Load HALF signed, addr=0x2002, rdata=0x8001_1234, rvalid one cycle after grant -> rdata_o=0xFFFF8001, done_o at cycle 3.
REQ-041 Load BYTE unsigned with grant withheld 5 cycles -> dmem_req_o and dmem_addr_o stable for 6 cycles, then normal completion, lsu_ready_o=0 throughout.
REQ-042 Load with no rvalid, RESP_TIMEOUT=4 -> done_o with err_o=1 and rdata_o=0 after 4 WAIT cycles; rvalid on the timeout cycle -> err_o=0.
REQ-043 Load WORD at addr=0x3001: with LSU_MISALIGN_TRAP_EN, no request and done_o+err_o at cycle 1; without the macro, dmem_addr=0x3000 and be=1111.
REQ-044 Reset asserted in WAIT, then rvalid arriving after reset -> IDLE, no done_o, rvalid ignored, next operation completes normally.
